dm_access_ctrl: RTL and testbench
=================================

// Module: dm_access_ctrl
// PURPOSE
//  Sequences the single-port data memory (DM) behind the MEM stage and shares it between two
//  requesters: the pipeline MEM stage (P, high priority) and a loader/debug port (L).
//  Issues one registered access at a time and waits a fixed read latency.
//  Returns read data with a one-cycle done pulse, and drives p_stall to freeze the pipeline
//  while a P access is outstanding.
// PARAMETERS
//  RD_LATENCY   1     cycles from mem_en (read) to valid mem_rdata; legal range 1..7
//  ADDR_LIMIT   4096  number of DM words; byte addr >= 4*ADDR_LIMIT is out of range
//  STARVE_LIMIT 4     consecutive P grants while L waits before L is forced through
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  p_req      in   1   P access request; level, held until p_done
//  p_we       in   1   P write (1) / read (0)
//  p_addr     in   32  P byte address
//  p_wdata    in   32  P write data
//  p_pc       in   32  PC of the P instruction, forwarded to DM
//  p_rdata    out  32  P read data, valid while p_done=1
//  p_done     out  1   one-cycle completion pulse for P
//  p_stall    out  1   = p_req & ~p_done (combinational)
//  l_req, l_we, l_addr[31:0], l_wdata[31:0]   in   L request, same rules as P
//  l_rdata    out  32  L read data, valid while l_done=1
//  l_done     out  1   one-cycle completion pulse for L
//  mem_en, mem_we   out  1   DM strobe and write enable, registered
//  mem_addr   out  32  {addr[31:2],2'b00}, registered
//  mem_wdata, mem_pc   out  32  registered; mem_pc=0 for L accesses
//  mem_rdata  in   32  DM read data
// BEHAVIOUR
//  - reset low: state=IDLE, streak=0, all outputs 0; any in-flight access is abandoned and
//    mem_en/mem_we drop immediately (no partial write completes).
//  - FSM IDLE->ISSUE->(WAIT)->DONE->IDLE.
//  - IDLE: select the requester, latch its fields, go to ISSUE.
//    Out-of-range address: skip ISSUE, go straight to DONE with rdata=0 and no DM access.
//  - Selection: P wins unless l_req=1 and streak==STARVE_LIMIT; then L wins.
//    Each P grant while l_req=1 increments streak. An L grant, or l_req=0, clears streak.
//  - ISSUE (1 cycle): mem_en=1, mem_we=latched we.
//    Write -> DONE. Read -> WAIT with counter=RD_LATENCY.
//  - WAIT: decrement counter; when it reaches 0, capture mem_rdata and go to DONE.
//  - DONE (1 cycle): done pulse for the granted requester, rdata held from capture.
//    Next state is always IDLE.
//  - Latency from req rising in IDLE: write done at cycle +2; read done at cycle +2+RD_LATENCY.
//  - Back-to-back: a requester drops req in the cycle after done. A req still high in IDLE is
//    treated as a new request.
//  - Dropping req before done is a protocol violation. The access still completes and the
//    done pulse is still emitted.
//  - P and L rising in the same IDLE cycle: P granted, L held (p_stall unaffected by L).
//  - Requests arriving in ISSUE, WAIT or DONE wait until IDLE; no queueing beyond the req level.
//  - Only one of p_done/l_done is ever high; mem_en is high only in ISSUE.
// CONFIGURATION
//  - DM_ACCESS_TRACE_EN defined: on every ISSUE write, $display
//    "@%h: *%h <= %h" (mem_pc, mem_addr, mem_wdata). For L writes, mem_pc prints as 00000000.
//  - Not defined: no trace code; the logic is otherwise identical.
// TESTING
//  - P read 0x00000010, RD_LATENCY=1, mem_rdata=0xDEADBEEF -> mem_en in cycle 1,
//    p_done+p_rdata=0xDEADBEEF in cycle 3, p_stall high in cycles 0-2.
//  - P write 0x0000000C data 0x12345678 -> mem_we=1, mem_addr=0x0000000C in cycle 1;
//    p_done in cycle 2.
//  - P and L both continuously requesting, STARVE_LIMIT=4 -> grant order P,P,P,P,L,P,P,P,P,L.
//  - P read 0x00004000 (out of range, ADDR_LIMIT=4096) -> no mem_en;
//    p_done in cycle 1 with p_rdata=0.
//  - reset driven low during WAIT of an L read -> all outputs 0 asynchronously;
//    after release, IDLE with no l_done.
//  - P addr 0x00000013 -> mem_addr=0x00000010; RD_LATENCY=3 read done at cycle 5.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer that shares one DM port between the pipeline (P) and a loader (L).
// Optional write trace on DM_ACCESS_TRACE_EN (default build: undefined, no trace code).
module dm_access_ctrl #(
    parameter int RD_LATENCY   = 1,
    parameter int ADDR_LIMIT   = 4096,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        p_req_i,
    input  logic        p_we_i,
    input  logic [31:0] p_addr_i,
    input  logic [31:0] p_wdata_i,
    input  logic [31:0] p_pc_i,
    output logic [31:0] p_rdata_o,
    output logic        p_done_o,
    output logic        p_stall_o,
    input  logic        l_req_i,
    input  logic        l_we_i,
    input  logic [31:0] l_addr_i,
    input  logic [31:0] l_wdata_i,
    output logic [31:0] l_rdata_o,
    output logic        l_done_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] mem_pc_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int          SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [32:0] ADDR_BYTES = 33'(ADDR_LIMIT) << 2;
    localparam logic [2:0]  LAT        = 3'(RD_LATENCY);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e         state_q;
    logic [SW-1:0]  streak_q;
    logic [SW-1:0]  streak_d;
    logic [2:0]     cnt_q;
    logic           gnt_l_q;
    logic           mem_en_q;
    logic           mem_we_q;
    logic [31:0]    mem_addr_q;
    logic [31:0]    mem_wdata_q;
    logic [31:0]    mem_pc_q;
    logic           p_done_q;
    logic           l_done_q;
    logic [31:0]    p_rdata_q;
    logic [31:0]    l_rdata_q;

    logic           take_l;
    logic           sel_we;
    logic           sel_oor;
    logic [31:0]    sel_addr;
    logic [31:0]    sel_wdata;
    logic [31:0]    sel_pc;

    // P has priority unless L has already been passed over STARVE_LIMIT times in a row.
    always_comb begin
        take_l    = l_req_i && (!p_req_i || (streak_q == SW'(STARVE_LIMIT)));
        sel_we    = take_l ? l_we_i    : p_we_i;
        sel_addr  = take_l ? l_addr_i  : p_addr_i;
        sel_wdata = take_l ? l_wdata_i : p_wdata_i;
        sel_pc    = take_l ? 32'h0     : p_pc_i;
        sel_oor   = ({1'b0, sel_addr} >= ADDR_BYTES);
        streak_d  = streak_q;
        if (take_l || !l_req_i) begin
            streak_d = '0;
        end else if (p_req_i) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            cnt_q       <= '0;
            gnt_l_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_pc_q    <= '0;
            p_done_q    <= 1'b0;
            l_done_q    <= 1'b0;
            p_rdata_q   <= '0;
            l_rdata_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    streak_q <= streak_d;
                    if (p_req_i || l_req_i) begin
                        gnt_l_q <= take_l;
                        if (sel_oor) begin
                            // Out-of-range: answer with zero data, never touch the DM.
                            state_q  <= DONE;
                            p_done_q <= !take_l;
                            l_done_q <= take_l;
                        end else begin
                            state_q     <= ISSUE;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= sel_we;
                            mem_addr_q  <= {sel_addr[31:2], 2'b00};
                            mem_wdata_q <= sel_wdata;
                            mem_pc_q    <= sel_pc;
                        end
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        state_q  <= DONE;
                        p_done_q <= !gnt_l_q;
                        l_done_q <= gnt_l_q;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= LAT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q  <= DONE;
                        p_done_q <= !gnt_l_q;
                        l_done_q <= gnt_l_q;
                        if (gnt_l_q) l_rdata_q <= mem_rdata_i;
                        else         p_rdata_q <= mem_rdata_i;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    p_done_q  <= 1'b0;
                    l_done_q  <= 1'b0;
                    p_rdata_q <= '0;
                    l_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DM_ACCESS_TRACE_EN
    always_ff @(posedge clk_i) begin
        if (mem_en_q && mem_we_q) begin
            $display("@%h: *%h <= %h", mem_pc_q, mem_addr_q, mem_wdata_q);
        end
    end
`endif

    // Reset gates the stall too, so every output reads zero while reset is held.
    assign p_stall_o   = rst_ni & p_req_i & ~p_done_q;
    assign p_done_o    = p_done_q;
    assign l_done_o    = l_done_q;
    assign p_rdata_o   = p_rdata_q;
    assign l_rdata_o   = l_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_pc_o    = mem_pc_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: table of single P accesses plus arbitration and reset sequences.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        p_req = 1'b0, p_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0, p_pc = '0, l_addr = '0, l_wdata = '0, mem_rdata = '0;

    logic [31:0] p_rdata1, l_rdata1, addr1, wdata1, pc1;
    logic        p_done1, p_stall1, l_done1, en1, we1;
    logic [31:0] p_rdata3, l_rdata3, addr3, wdata3, pc3;
    logic        p_done3, p_stall3, l_done3, en3, we3;

    logic        use3 = 1'b0;
    logic [31:0] o_prdata, o_addr, o_wdata, o_pc;
    logic        o_pdone, o_stall, o_ldone, o_en, o_we;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_access_ctrl #(.RD_LATENCY(1), .ADDR_LIMIT(4096), .STARVE_LIMIT(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .p_req_i(p_req), .p_we_i(p_we), .p_addr_i(p_addr), .p_wdata_i(p_wdata), .p_pc_i(p_pc),
        .p_rdata_o(p_rdata1), .p_done_o(p_done1), .p_stall_o(p_stall1),
        .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_rdata_o(l_rdata1), .l_done_o(l_done1),
        .mem_en_o(en1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wdata1), .mem_pc_o(pc1),
        .mem_rdata_i(mem_rdata)
    );

    dm_access_ctrl #(.RD_LATENCY(3), .ADDR_LIMIT(4096), .STARVE_LIMIT(4)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .p_req_i(p_req), .p_we_i(p_we), .p_addr_i(p_addr), .p_wdata_i(p_wdata), .p_pc_i(p_pc),
        .p_rdata_o(p_rdata3), .p_done_o(p_done3), .p_stall_o(p_stall3),
        .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_rdata_o(l_rdata3), .l_done_o(l_done3),
        .mem_en_o(en3), .mem_we_o(we3), .mem_addr_o(addr3), .mem_wdata_o(wdata3), .mem_pc_o(pc3),
        .mem_rdata_i(mem_rdata)
    );

    always_comb begin
        o_prdata = use3 ? p_rdata3 : p_rdata1;
        o_pdone  = use3 ? p_done3  : p_done1;
        o_stall  = use3 ? p_stall3 : p_stall1;
        o_ldone  = use3 ? l_done3  : l_done1;
        o_en     = use3 ? en3      : en1;
        o_we     = use3 ? we3      : we1;
        o_addr   = use3 ? addr3    : addr1;
        o_wdata  = use3 ? wdata3   : wdata1;
        o_pc     = use3 ? pc3      : pc1;
    end

    typedef struct {
        logic        lat3;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] mrd;
        int          en_cyc;
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
        int          done_cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        p_req = 1'b0;
        l_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int          en_c, done_c, stall_n, ldone_n;
        logic [31:0] a_at, wd_at, pc_at, rd_at;
        logic        we_at;
        en_c = -1; done_c = -1; stall_n = 0; ldone_n = 0;
        a_at = '0; wd_at = '0; pc_at = '0; rd_at = '0; we_at = 1'b0;
        do_reset();
        use3      = v.lat3;
        mem_rdata = v.mrd;
        p_req = 1'b1; p_we = v.we; p_addr = v.addr; p_wdata = v.wdata; p_pc = v.pc;
        for (int k = 0; k < 20 && done_c < 0; k++) begin
            if (k == 0) #1;
            else @(negedge clk);
            if (o_en && en_c < 0) begin
                en_c = k; a_at = o_addr; we_at = o_we; wd_at = o_wdata; pc_at = o_pc;
            end
            if (o_stall) stall_n++;
            if (o_ldone) ldone_n++;
            if (o_pdone) begin
                done_c = k;
                rd_at  = o_prdata;
            end
        end
        #1 p_req = 1'b0;
        chk($sformatf("v%0d_en_cycle", i), 32'(en_c), 32'(v.en_cyc));
        if (v.en_cyc >= 0) begin
            chk($sformatf("v%0d_mem_addr", i), a_at, v.exp_addr);
            chk($sformatf("v%0d_mem_we", i), 32'(we_at), 32'(v.we));
            chk($sformatf("v%0d_mem_wdata", i), wd_at, v.wdata);
            chk($sformatf("v%0d_mem_pc", i), pc_at, v.pc);
        end
        chk($sformatf("v%0d_done_cycle", i), 32'(done_c), 32'(v.done_cyc));
        chk($sformatf("v%0d_p_rdata", i), rd_at, v.exp_rd);
        chk($sformatf("v%0d_stall_cycles", i), 32'(stall_n), 32'(v.done_cyc));
        chk($sformatf("v%0d_no_l_done", i), 32'(ldone_n), 32'd0);
    endtask

    initial begin
        int          n, both_n, ld_n, en_n;
        logic [9:0]  seq;
        logic [31:0] pc_l;

        //             lat3 we  addr          wdata         pc            mrd           en  exp_addr      exp_rd        done
        vecs[0] = '{1'b0, 1'b0, 32'h00000010, 32'h00000000, 32'h00000100, 32'hDEADBEEF, 1, 32'h00000010, 32'hDEADBEEF, 3};
        vecs[1] = '{1'b0, 1'b1, 32'h0000000C, 32'h12345678, 32'h00000104, 32'hFFFFFFFF, 1, 32'h0000000C, 32'h00000000, 2};
        vecs[2] = '{1'b0, 1'b0, 32'h00004000, 32'h00000000, 32'h00000108, 32'hCAFEF00D, -1, 32'h00000000, 32'h00000000, 1};
        vecs[3] = '{1'b0, 1'b0, 32'h00003FFC, 32'h00000000, 32'h0000010C, 32'hA5A5A5A5, 1, 32'h00003FFC, 32'hA5A5A5A5, 3};
        vecs[4] = '{1'b0, 1'b0, 32'h00000013, 32'h00000000, 32'h00000110, 32'h0BADF00D, 1, 32'h00000010, 32'h0BADF00D, 3};
        vecs[5] = '{1'b0, 1'b1, 32'hFFFFFFF0, 32'h11112222, 32'h00000114, 32'h00000000, -1, 32'h00000000, 32'h00000000, 1};
        vecs[6] = '{1'b0, 1'b1, 32'h00003FFE, 32'h9ABCDEF0, 32'h00000118, 32'h00000000, 1, 32'h00003FFC, 32'h00000000, 2};
        vecs[7] = '{1'b1, 1'b0, 32'h00000013, 32'h00000000, 32'h0000011C, 32'h0BADF00D, 1, 32'h00000010, 32'h0BADF00D, 5};

        // Reset state, with a P request already pending.
        #2 rst_n = 1'b0;
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h40; p_wdata = 32'hFFFF0000; p_pc = 32'h200;
        #1;
        chk("rst_mem_ctrl", {29'd0, en1, we1, p_stall1}, 32'd0);
        chk("rst_mem_addr", addr1 | wdata1 | pc1, 32'd0);
        chk("rst_done_rdata", {30'd0, p_done1, l_done1} | p_rdata1 | l_rdata1, 32'd0);
        p_req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
        use3 = 1'b0;

        // Both requesters held high: L is forced through after four P grants.
        do_reset();
        mem_rdata = '0;
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h40; p_wdata = 32'h1; p_pc = 32'h400;
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h80; l_wdata = 32'h2;
        n = 0; both_n = 0; seq = '0; pc_l = 32'hFFFFFFFF;
        for (int k = 0; k < 60 && n < 10; k++) begin
            @(negedge clk);
            if (p_done1 && l_done1) both_n++;
            if (en1 && addr1 == 32'h80) pc_l = pc1;
            if (p_done1 && n < 10) begin seq[n] = 1'b0; n++; end
            else if (l_done1 && n < 10) begin seq[n] = 1'b1; n++; end
        end
        #1 p_req = 1'b0; l_req = 1'b0;
        chk("starve_grants", 32'(n), 32'd10);
        chk("starve_order", {22'd0, seq}, 32'h00000210);
        chk("starve_exclusive_done", 32'(both_n), 32'd0);
        chk("starve_l_pc_zero", pc_l, 32'd0);

        // Reset asserted mid-WAIT of an L read (RD_LATENCY=3 instance).
        do_reset();
        use3 = 1'b1;
        mem_rdata = 32'h55AA55AA;
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h20;
        repeat (3) @(negedge clk);
        chk("wait_pre_en", {31'd0, en3}, 32'd0);
        chk("wait_pre_addr", addr3, 32'h20);
        rst_n = 1'b0;
        #1;
        chk("wait_rst_addr", addr3, 32'd0);
        chk("wait_rst_ctrl", {28'd0, en3, we3, l_done3, p_done3} | l_rdata3, 32'd0);
        l_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ld_n = 0; en_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (l_done3) ld_n++;
            if (en3) en_n++;
        end
        chk("wait_rst_no_l_done", 32'(ld_n), 32'd0);
        chk("wait_rst_no_mem_en", 32'(en_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
